// File: rtl/alu_mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq_if
// Brief    : Request/response handshake bundle between decode, the
//            alu_mdu_seq execution unit and writeback.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;

    modport master (
        output in_valid, op, op1, op2, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, op, op1, op2, out_ready,
        output in_ready, out_valid, res
    );
endinterface
`default_nettype wire

// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq
// Brief    : Handshaked RV32/RV64 ALU with iterative radix-2 M-extension.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_seq #(
    parameter int XLEN = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_mdu_seq_if.slave bus
);
    localparam int              SHW      = $clog2(XLEN);
    localparam logic [1:0]      S_IDLE   = 2'd0;
    localparam logic [1:0]      S_MUL    = 2'd1;
    localparam logic [1:0]      S_DIV    = 2'd2;
    localparam logic [1:0]      S_DONE   = 2'd3;
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN-1);

    logic [1:0]        state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [1:0]        sel_q, sel_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              w_accept, w_is_mul, w_is_div, w_fast, w_last;
    logic              w_s1, w_s2, w_sign1, w_sign2;
    logic [XLEN-1:0]   w_abs1, w_abs2, w_alu, w_fast_res, w_quick;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN:0]     w_msum, w_dshift, w_ddiff;
    logic [2*XLEN-1:0] w_mnext, w_mfix;
    logic [XLEN-1:0]   w_mres, w_rnew, w_qnew, w_dres;

    assign w_accept = bus.in_valid && (state_q == S_IDLE);
    assign w_is_mul = (bus.op[4:2] == 3'b100);
    assign w_is_div = (bus.op[4:2] == 3'b101);
    assign w_last   = (cnt_q == CNT_LAST);
    assign w_shamt  = bus.op2[SHW-1:0];

    // Which operands are treated as signed: op1 for MUL/MULH/MULHSU/DIV/REM, op2 for MUL/MULH/DIV/REM
    assign w_s1    = (w_is_mul && bus.op[1:0] != 2'b11) || (w_is_div && !bus.op[0]);
    assign w_s2    = (w_is_mul && !bus.op[1]) || (w_is_div && !bus.op[0]);
    assign w_sign1 = w_s1 && bus.op1[XLEN-1];
    assign w_sign2 = w_s2 && bus.op2[XLEN-1];
    assign w_abs1  = w_sign1 ? -bus.op1 : bus.op1;
    assign w_abs2  = w_sign2 ? -bus.op2 : bus.op2;

    always_comb begin
        w_alu = '0;
        case (bus.op)
            5'b00000: w_alu = bus.op1 + bus.op2;
            5'b00001: w_alu = bus.op1 - bus.op2;
            5'b00010: w_alu = bus.op1 & bus.op2;
            5'b00011: w_alu = bus.op1 | bus.op2;
            5'b00100: w_alu = bus.op1 ^ bus.op2;
            5'b00101: w_alu = bus.op1 << w_shamt;
            5'b00110: w_alu = bus.op1 >> w_shamt;
            5'b00111: w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            5'b01000: w_alu = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
            5'b01001: w_alu = $signed(bus.op1) >>> w_shamt;
            5'b01111: w_alu = bus.op1;
            default:  w_alu = '0;
        endcase
    end

    // Divide-by-zero and signed overflow resolve without iterating
    always_comb begin
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (w_is_div && bus.op2 == '0) begin
            w_fast     = 1'b1;
            w_fast_res = bus.op[1] ? bus.op1 : ONES;
        end else if (w_is_div && !bus.op[0] && bus.op1 == MIN_NEG && bus.op2 == ONES) begin
            w_fast     = 1'b1;
            w_fast_res = bus.op[1] ? '0 : bus.op1;
        end
    end
    assign w_quick = w_fast ? w_fast_res : w_alu;

    // Shift-add step: acc = {partial_hi, remaining multiplier bits}
    assign w_msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign w_mnext = {w_msum, acc_q[XLEN-1:1]};
    assign w_mfix  = neg_q ? -w_mnext : w_mnext;
    assign w_mres  = (sel_q == 2'b00) ? w_mfix[XLEN-1:0] : w_mfix[2*XLEN-1:XLEN];

    // Restoring step: acc = {partial remainder, dividend/quotient shift register}
    assign w_dshift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign w_ddiff  = w_dshift - {1'b0, opnd_q};
    assign w_rnew   = w_ddiff[XLEN] ? w_dshift[XLEN-1:0] : w_ddiff[XLEN-1:0];
    assign w_qnew   = {acc_q[XLEN-2:0], ~w_ddiff[XLEN]};
    assign w_dres   = sel_q[1] ? (rneg_q ? -w_rnew : w_rnew) : (neg_q ? -w_qnew : w_qnew);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_accept) begin
                if (w_is_mul)                 state_d = S_MUL;
                else if (w_is_div && !w_fast) state_d = S_DIV;
                else                          state_d = S_DONE;
            end
            S_MUL:   if (w_last) state_d = S_DONE;
            S_DIV:   if (w_last) state_d = S_DONE;
            default: if (bus.out_ready) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end
    assign bus.res = res_q;

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        sel_d  = sel_q;
        res_d  = res_q;
        case (state_q)
            S_IDLE: if (w_accept) begin
                cnt_d  = '0;
                sel_d  = bus.op[1:0];
                neg_d  = w_sign1 ^ w_sign2;
                rneg_d = w_sign1;
                if (w_is_mul) begin
                    acc_d  = {{XLEN{1'b0}}, w_abs2};
                    opnd_d = w_abs1;
                end else if (w_is_div && !w_fast) begin
                    acc_d  = {{XLEN{1'b0}}, w_abs1};
                    opnd_d = w_abs2;
                end else begin
                    res_d  = w_quick;
                end
            end
            S_MUL: begin
                acc_d = w_mnext;
                cnt_d = cnt_q + 1'b1;
                if (w_last) res_d = w_mres;
            end
            S_DIV: begin
                acc_d = {w_rnew, w_qnew};
                cnt_d = cnt_q + 1'b1;
                if (w_last) res_d = w_dres;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            sel_q  <= '0;
            res_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            sel_q  <= sel_d;
            res_q  <= res_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu_seq
// Brief    : Directed self-checking bench for alu_mdu_seq (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_seq;
    localparam int XLEN = 32;
    localparam int LAT_ITER = XLEN + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mdu_seq_if #(.XLEN(XLEN)) bus ();

    alu_mdu_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [XLEN-1:0] exp;
        int              lat;
        string           tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for out_valid, then score it
    task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat, input string tag);
        sb_t e;
        int  n;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        sb_q.push_back('{exp: exp, lat: lat, tag: tag});
        bus.op       = op;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op1      = $urandom;
        bus.op2      = $urandom;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
            check({e.tag, "_res"}, 64'(bus.res), 64'(e.exp));
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] held;
        int              seen;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_res",       64'(bus.res),       64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(5'b00001, 32'd5,        32'd7,        32'hFFFFFFFE, 1, "sub");         finish_op();
        run_op(5'b00111, 32'hFFFFFFFF, 32'd1,        32'd1,        1, "slt");         finish_op();
        run_op(5'b01000, 32'hFFFFFFFF, 32'd1,        32'd0,        1, "sltu");        finish_op();
        run_op(5'b01001, 32'h80000000, 32'd4,        32'hF8000000, 1, "sra");         finish_op();
        run_op(5'b00101, 32'd1,        32'h21,       32'd2,        1, "sll");         finish_op();
        run_op(5'b00110, 32'h80000000, 32'd4,        32'h08000000, 1, "srl");         finish_op();
        run_op(5'b00010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, "and");         finish_op();
        run_op(5'b00011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1, "or");          finish_op();
        run_op(5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1, "xor");         finish_op();
        run_op(5'b01111, 32'hDEADBEEF, 32'd9,        32'hDEADBEEF, 1, "pass");        finish_op();
        run_op(5'b01010, 32'hDEADBEEF, 32'd9,        32'd0,        1, "illegal");     finish_op();

        run_op(5'b10000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_ITER, "mul");     finish_op();
        run_op(5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_ITER, "mulh");    finish_op();
        run_op(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_ITER, "mulhu");   finish_op();
        run_op(5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_ITER, "mulhsu");  finish_op();
        run_op(5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_ITER, "div");     finish_op();
        run_op(5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_ITER, "rem");     finish_op();
        run_op(5'b10101, 32'd100,      32'd7,        32'h0000000E, LAT_ITER, "divu");    finish_op();
        run_op(5'b10111, 32'd100,      32'd7,        32'd2,        LAT_ITER, "remu");    finish_op();

        run_op(5'b10100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "div_by0");     finish_op();
        run_op(5'b10111, 32'h1234,     32'd0,        32'h1234,     1, "remu_by0");    finish_op();
        run_op(5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");     finish_op();
        run_op(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf");     finish_op();

        // Back-pressure: DONE holds while the consumer stalls; new requests are ignored
        bus.out_ready = 1'b0;
        run_op(5'b10000, 32'd6, 32'd7, 32'h2A, LAT_ITER, "bp_mul");
        held = bus.res;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.op       = 5'b00000;
            bus.op1      = 32'd100;
            bus.op2      = 32'd1;
            @(posedge clk);
            #1;
            check("bp_res_hold",   64'(bus.res),       64'(held));
            check("bp_out_valid",  64'(bus.out_valid), 64'd1);
            check("bp_in_ready",   64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        finish_op();
        check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_res",       64'(bus.res),       64'h2A);

        // Reset in the middle of a divide aborts it
        bus.op       = 5'b10101;
        bus.op1      = 32'd100;
        bus.op2      = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("div_busy_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_res",       64'(bus.res),       64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);
        run_op(5'b00000, 32'd2, 32'd3, 32'd5, 1, "add_after_rst");
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
